// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: IF/ID-style pipeline register with stall, flush and flush counter; PIPE_STAGE_SKID_EN selects a 2-entry skid buffer
module pipe_stage_reg #(
  parameter int DATA_W = 96,
  parameter int FCNT_W = 16
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [DATA_W-1:0] In_Data,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [DATA_W-1:0] Out_Data,
  input  logic              Stall,
  input  logic              Flush,
  output logic [1:0]        Occupancy,
  output logic [FCNT_W-1:0] Flush_Count
);
  logic [1:0]        occ;
  logic [DATA_W-1:0] e0, e1;
  logic              in_fire, out_fire;
  // Handshake: the skid build decouples In_Ready from Out_Ready, the single-entry build passes it through
  always_comb begin
`ifdef PIPE_STAGE_SKID_EN
    In_Ready  = (occ != 2'd2) & ~Stall & ~Flush;
    Occupancy = occ;
`else
    In_Ready  = ((occ == 2'd0) | Out_Ready) & ~Stall & ~Flush;
    Occupancy = {1'b0, occ[0]};
`endif
    Out_Valid = (occ != 2'd0) & ~Stall;
    Out_Data  = (occ == 2'd0) ? '0 : e0;
    in_fire   = In_Valid & In_Ready;
    out_fire  = Out_Valid & Out_Ready;
  end
  // Storage: e0 is the head; flush wins over everything, stall holds because it blocks both fires
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      occ         <= 2'd0;
      e0          <= '0;
      e1          <= '0;
      Flush_Count <= '0;
    end else if (Flush) begin
      occ <= 2'd0;
      e0  <= '0;
      e1  <= '0;
      if (occ != 2'd0 && !(&Flush_Count)) Flush_Count <= Flush_Count + FCNT_W'(1);
    end else if (in_fire && out_fire) begin
      e0 <= In_Data;
    end else if (out_fire) begin
      e0  <= e1;
      e1  <= '0;
      occ <= occ - 2'd1;
    end else if (in_fire) begin
      e0  <= (occ == 2'd0) ? In_Data : e0;
      e1  <= (occ == 2'd0) ? e1 : In_Data;
      occ <= occ + 2'd1;
    end
  end
endmodule
